// File: rtl/isp_dram_reader.sv
// isp_dram_reader: AXI4 read master fetching one raw picture from DRAM and
// streaming it beat by beat into the ISP core, splitting bursts at 4 KB pages.
module isp_dram_reader #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          PIC_BYTES = 3072,
    parameter int          DATA_W    = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        pic_no,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        arid_s_inf,
    output logic [31:0]       araddr_s_inf,
    output logic [7:0]        arlen_s_inf,
    output logic [2:0]        arsize_s_inf,
    output logic [1:0]        arburst_s_inf,
    output logic              arvalid_s_inf,
    input  logic              arready_s_inf,
    input  logic [3:0]        rid_s_inf,
    input  logic [DATA_W-1:0] rdata_s_inf,
    input  logic [1:0]        rresp_s_inf,
    input  logic              rlast_s_inf,
    input  logic              rvalid_s_inf,
    output logic              rready_s_inf,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);
    localparam int BEAT_B    = DATA_W / 8;
    localparam int BEAT_SH   = $clog2(BEAT_B);
    localparam int PIC_BEATS = PIC_BYTES / BEAT_B;
    localparam int REM_W     = $clog2(PIC_BEATS + 1);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [7:0]       arlen_q, arlen_d;
    logic             arvalid_q, arvalid_d;
    logic [15:0]      page_beats, blen;
    logic             xfer;
    logic             unused_rid;

    // Beats left before the next 4 KB page boundary caps the burst length.
    assign page_beats = 16'((13'h1000 - {1'b0, addr_q[11:0]}) >> BEAT_SH);
    assign blen       = (16'(rem_q) < page_beats) ? 16'(rem_q) : page_beats;
    assign xfer       = (state_q == R) && rvalid_s_inf && m_ready;
    assign unused_rid = ^rid_s_inf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        err_d     = err_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = BASE_ADDR + 32'(pic_no) * 32'(PIC_BYTES);
                rem_d   = REM_W'(PIC_BEATS);
                err_d   = 1'b0;
                state_d = AR;
            end
            // First AR cycle registers the request; arvalid follows a cycle later.
            AR: if (!arvalid_q) begin
                araddr_d  = addr_q;
                arlen_d   = 8'(blen - 16'd1);
                arvalid_d = 1'b1;
            end else if (arready_s_inf) begin
                arvalid_d = 1'b0;
                state_d   = R;
            end
            R: if (xfer) begin
                rem_d  = rem_q - REM_W'(1);
                addr_d = addr_q + 32'(BEAT_B);
                if (rresp_s_inf != 2'b00) err_d = 1'b1;
                if (rlast_s_inf) state_d = (rem_q == REM_W'(1)) ? DONE : AR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q == AR) || (state_q == R);
    assign done          = state_q == DONE;
    assign err           = err_q;
    assign arid_s_inf    = 4'd0;
    assign araddr_s_inf  = araddr_q;
    assign arlen_s_inf   = arlen_q;
    assign arsize_s_inf  = 3'b100;
    assign arburst_s_inf = 2'b01;
    assign arvalid_s_inf = arvalid_q;
    assign rready_s_inf  = (state_q == R) && m_ready;
    assign m_valid       = (state_q == R) && rvalid_s_inf;
    assign m_data        = rdata_s_inf;
    assign m_last        = m_valid && (rem_q == REM_W'(1));
endmodule

// File: tb/tb_isp_dram_reader.sv
// tb_isp_dram_reader: directed/randomized bench with a DRAM responder and a
// picture-level reference model of bursts, beats and flags.
module tb_isp_dram_reader;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   pic_no;
    logic         busy, done, err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic         m_valid, m_last, m_ready;
    logic [127:0] m_data;

    always #5 clk = ~clk;

    isp_dram_reader dut (
        .clk(clk), .rst(rst), .start(start), .pic_no(pic_no),
        .busy(busy), .done(done), .err(err),
        .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen),
        .arsize_s_inf(arsize), .arburst_s_inf(arburst),
        .arvalid_s_inf(arvalid), .arready_s_inf(arready),
        .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp),
        .rlast_s_inf(rlast), .rvalid_s_inf(rvalid), .rready_s_inf(rready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    typedef struct packed {logic [31:0] a; int n;} burst_t;

    int errors = 0, checks = 0;
    int ar_wait = 0, ar_cnt = 0, mr_mode = 0, rv_mode = 0, inj = -1, beat_cnt = 0;
    int done_cnt = 0, stab_bad = 0, hs_bad = 0, cur_left = 0;
    logic [31:0]  cur_a = '0, prev_addr = '0;
    logic [7:0]   prev_len = '0;
    logic         prev_wait = 1'b0, ar_fire, r_fire;
    burst_t       pend[$];
    burst_t       b;
    logic [31:0]  rec_addr[$];
    logic [7:0]   rec_len[$];
    logic [127:0] rec_data[$];
    logic         rec_last[$];

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        return {a, a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DRAM responder and output monitor: sample at negedge, drive at posedge+1.
    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = 0; m_ready = 1;
        forever begin
            @(negedge clk);
            ar_fire = arvalid && arready;
            r_fire  = rvalid && rready;
            if (m_valid && m_ready) begin
                rec_data.push_back(m_data);
                rec_last.push_back(m_last);
            end
            if ((rready && !m_ready) || (m_valid && !rvalid) || (m_valid && m_data !== rdata) ||
                ((m_valid && m_ready) != r_fire)) hs_bad++;
            if (done) done_cnt++;
            if (prev_wait && (!arvalid || araddr !== prev_addr || arlen !== prev_len)) stab_bad++;
            prev_wait = arvalid && !arready;
            prev_addr = araddr;
            prev_len  = arlen;
            if (ar_fire) begin
                rec_addr.push_back(araddr);
                rec_len.push_back(arlen);
                pend.push_back('{a: araddr, n: int'(arlen) + 1});
            end
            @(posedge clk);
            #1;
            if (rst) begin
                pend.delete();
                cur_left = 0; ar_cnt = 0; prev_wait = 0;
                arready = 0; rvalid = 0; rlast = 0; rresp = 0;
            end else begin
                if (r_fire) begin
                    beat_cnt++;
                    cur_a += 32'd16;
                    cur_left--;
                end
                if (cur_left == 0 && pend.size() > 0) begin
                    b = pend.pop_front();
                    cur_a = b.a;
                    cur_left = b.n;
                end
                if (ar_fire) ar_cnt = 0;
                if (arvalid) begin
                    arready = (ar_cnt >= ar_wait);
                    ar_cnt++;
                end else begin
                    arready = 0;
                    ar_cnt = 0;
                end
                if (!(rvalid && !r_fire))
                    rvalid = (cur_left > 0) && (rv_mode == 0 || $urandom_range(0, 3) != 0);
                rdata = mem_word(cur_a);
                rlast = (cur_left == 1);
                rresp = (beat_cnt == inj) ? 2'b10 : 2'b00;
                m_ready = (mr_mode == 0) ? 1'b1 : (mr_mode == 1) ? ~m_ready : 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic run_pic(input int p, input int inj_i, input bit poke_r, input bit poke_done);
        logic [31:0] a, last, pb;
        logic [31:0] ea[$];
        logic [7:0]  el[$];
        rec_addr.delete(); rec_len.delete(); rec_data.delete(); rec_last.delete();
        done_cnt = 0; stab_bad = 0; hs_bad = 0; beat_cnt = 0; inj = inj_i;
        @(negedge clk);
        start = 1; pic_no = 4'(p);
        @(negedge clk);
        start = 0; pic_no = 4'($urandom_range(0, 15));
        check("busy_after_start", busy, 1);
        check("arvalid_not_yet", arvalid, 0);
        check("err_cleared_on_start", err, 0);
        @(negedge clk);
        check("arvalid_latency2", arvalid, 1);
        for (int c = 0; c < 4000; c++) begin
            if (done) break;
            start = poke_r && (c == 30);
            pic_no = 4'(p ^ 1);
            @(negedge clk);
        end
        start = 0;
        check("done_seen", done, 1);
        check("busy_low_at_done", busy, 0);
        check("err_at_done", err, (inj_i >= 0 && inj_i < 192));
        start = poke_done;
        pic_no = 4'(p);
        @(negedge clk);
        start = 0;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        @(negedge clk);
        check("start_in_done_ignored", busy | arvalid, 0);
        check("err_sticky", err, (inj_i >= 0 && inj_i < 192));
        check("done_pulse_count", done_cnt, 1);
        check("ar_stable_while_waiting", stab_bad, 0);
        check("stream_passthrough", hs_bad, 0);
        a = BASE + 32'(p) * 32'd3072;
        last = a + 32'd3071;
        if (a[31:12] == last[31:12]) begin
            ea.push_back(a); el.push_back(8'd191);
        end else begin
            pb = {last[31:12], 12'h000};
            ea.push_back(a);  el.push_back(8'((pb - a) / 16 - 1));
            ea.push_back(pb); el.push_back(8'((a + 32'd3072 - pb) / 16 - 1));
        end
        check("burst_count", rec_addr.size(), ea.size());
        for (int i = 0; i < ea.size() && i < rec_addr.size(); i++) begin
            check($sformatf("araddr[%0d] pic%0d", i, p), rec_addr[i], ea[i]);
            check($sformatf("arlen[%0d] pic%0d", i, p), rec_len[i], el[i]);
        end
        check("beat_count", rec_data.size(), 192);
        for (int i = 0; i < 192 && i < rec_data.size(); i++) begin
            check($sformatf("beat%0d data pic%0d", i, p), rec_data[i], mem_word(a + 32'(i) * 32'd16));
            check($sformatf("beat%0d last pic%0d", i, p), rec_last[i], i == 191);
        end
    endtask

    initial begin
        rst = 1; start = 0; pic_no = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_rready", rready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_constants", {arid, arsize, arburst}, {4'd0, 3'b100, 2'b01});
        rst = 0;
        run_pic(0, -1, 0, 0);
        run_pic(1, -1, 0, 0);
        run_pic(4, -1, 0, 0);
        run_pic(5, -1, 0, 1);
        ar_wait = 5; mr_mode = 1;
        run_pic(1, -1, 1, 0);
        ar_wait = 2; mr_mode = 2; rv_mode = 1;
        run_pic(2, 9, 0, 0);
        run_pic(7, -1, 0, 0);
        // Mid-picture reset with err already set, then the same picture again.
        rec_data.delete(); beat_cnt = 0; inj = 5;
        @(negedge clk);
        start = 1; pic_no = 4'd3;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if (beat_cnt >= 49) break;
        end
        check("rst_reached_beat50", beat_cnt >= 49, 1);
        check("err_before_rst", err, 1);
        rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_ar", {arvalid, araddr, arlen}, 0);
        check("arst_stream", {rready, m_valid, m_last}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        run_pic(3, -1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            ar_wait = $urandom_range(0, 4);
            run_pic($urandom_range(0, 15), -1, 0, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
